i2c_slave_regs: RTL and testbench
=================================

# i2c_slave_regs

I2C target (slave) that answers the byte-read/byte-write sequence our I2C master controller issues: 7-bit address, one pointer byte, then data bytes. It maps the bus onto a simple synchronous 8-bit register port with auto-incrementing pointer. It is used as the on-chip responder and as the bench partner for the master path. It oversamples open-drain SCL/SDA on `clk` and never stretches the clock.

## Interface
- `SLAVE_ADDR`, default 7'b1010111 (0x57): 7-bit bus address answered.
- `clk`  in  1  system clock; must be ≥ 16× SCL frequency.
- `rst`  in  1  synchronous, active-high reset.
- `scl_i`  in  1  SCL pad input (asynchronous).
- `sda_i`  in  1  SDA pad input (asynchronous).
- `sda_oe`  out  1  1 = pull SDA low; 0 = release (pad is open-drain).
- `reg_addr`  out  8  register pointer driven with every strobe.
- `reg_wr_en`  out  1  one-cycle write strobe.
- `reg_wdata`  out  8  write data, valid with `reg_wr_en`.
- `reg_rd_en`  out  1  one-cycle read strobe.
- `reg_rdata`  in  8  read data, valid exactly 1 cycle after `reg_rd_en`.
- `busy`  out  1  high from address match until STOP, START, or master NACK.

## Operation
- Input conditioning: 2-FF synchronizer per line, plus one delay stage for edge detection. Rise/fall events come from the synchronized values.
- START: SDA falls while SCL is high. Recognized in every state, including repeated start. Action: go to ADDR, bit counter = 0, `sda_oe`=0.
- STOP: SDA rises while SCL is high. Recognized in every state. Action: go to IDLE, `sda_oe`=0, `busy`=0.
- Bit rules:
  - Sample SDA on SCL rise.
  - Change `sda_oe` only on SCL fall.
  - MSB first; 3-bit counter counts 8 bits, then an ACK slot.
- States:
  - IDLE: wait for START.
  - ADDR: shift in 8 bits.
    - After the 8th rise, compare [7:1] with SLAVE_ADDR.
    - Match: on the 8th fall assert ACK (`sda_oe`=1), `busy`=1, go to ADDR_ACK.
    - Mismatch: go to IGNORE; SDA is never driven.
    - R/W=1: issue `reg_rd_en` (addr = pointer) on the cycle the match is detected; latch `reg_rdata` into the TX shift register.
  - ADDR_ACK: on the 9th fall release SDA.
    - R/W=0: go to PTR.
    - R/W=1: go to RDATA and drive TX bit7 on that same fall (`sda_oe` = ~bit).
  - PTR: shift in 8 bits; 8th fall ACK; load pointer; go to PTR_ACK; 9th fall release, go to WDATA.
  - WDATA: shift in 8 bits.
    - 8th fall: ACK, pulse `reg_wr_en` with `reg_addr`=pointer and `reg_wdata`=byte.
    - Pointer +1 on the cycle after the strobe.
    - Go to WDATA_ACK; 9th fall release, return to WDATA.
  - RDATA: drive bits 6..0 on successive falls; release SDA on the 8th fall; go to MACK.
  - MACK: sample master ACK on the 9th rise; pointer +1.
    - ACK (SDA=0): pulse `reg_rd_en` at the new pointer, latch the byte, drive its bit7 on the 9th fall, go to RDATA.
    - NACK: go to IGNORE, `busy`=0, no further read strobe.
  - IGNORE: SDA released; wait for START/STOP.
- Pointer arithmetic: 8-bit, wraps 0xFF→0x00. The pointer persists across transactions, so a current-address read (START, read address) uses the last pointer.
- General call (address 0) and 10-bit addressing are not supported; both are treated as mismatch.

## Timing
- Reset values: `sda_oe`=0, `reg_wr_en`=0, `reg_rd_en`=0, `reg_addr`=0x00, `reg_wdata`=0x00, `busy`=0, pointer=0x00, state IDLE.
- Pad-to-internal latency is 3 `clk` cycles. `sda_oe` changes on cycle 3 after the SCL fall at the pin; SCL low time must exceed 6 `clk`.
- `reg_wr_en` pulse: 1 cycle, at most 1 per byte, and only on a byte that is ACKed.
- `reg_rd_en` pulse: 1 cycle, issued ≥2 cycles before the SCL fall that needs bit7.
- START/STOP mid-byte: discard the partial byte, no strobe; `sda_oe`=0 on the same cycle the event is detected.
- `rst` mid-transfer: SDA released on the next clk; the block stays in IDLE until a fresh START. A byte in flight is lost.
- Simultaneous SCL and SDA edges in one sample are treated as a data bit, not START/STOP.

## Test plan
- Write: START, 0xAE, 0x10, 0xA5, 0x5A, STOP → ACK in 4 slots; `reg_wr_en` at (0x10, 0xA5) then (0x11, 0x5A); `busy` falls at STOP.
- Random read: START, 0xAE, 0x20, Sr, 0xAF; model returns 0x3C at 0x20 and 0xC3 at 0x21; master ACKs the first byte, NACKs the second, STOP → SDA carries 0x3C, 0xC3; `reg_rd_en` fires exactly twice (0x20, 0x21).
- Mismatch: START, 0xA0, 0x00, STOP → `sda_oe` stays 0 throughout; no strobes; `busy`=0.
- Wrap and persistence: pointer write 0xFF, data 0x11, 0x22 → writes to 0xFF and 0x00. Then START, 0xAF, NACK → read strobe at 0x01.
- Abort: STOP after 4 bits of a data byte → no `reg_wr_en`; `sda_oe`=0. Then `rst` asserted while driving a 0 bit → `sda_oe`=0 the next cycle; a subsequent full write transaction succeeds.

Source files
------------

// File: rtl/i2c_slave_regs.sv
// I2C target that maps the bus onto an 8-bit register port.
// Sequence: 7-bit address, one pointer byte, then data bytes with an
// auto-incrementing pointer. SCL/SDA are oversampled on clk and the
// clock is never stretched; SDA is only ever pulled low (open drain).
module i2c_slave_regs #(
  parameter logic [6:0] SLAVE_ADDR = 7'b1010111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic       reg_wr_en,
  output logic [7:0] reg_wdata,
  output logic       reg_rd_en,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_MACK,
    S_IGNORE
  } state_t;

  // Synchronizer stages plus one delay stage per line for edge detection
  logic scl_meta, scl_sync, scl_prev;
  logic sda_meta, sda_sync, sda_prev;

  logic scl_rise, scl_fall, start_det, stop_det;

  state_t     state, state_n;
  logic [2:0] cnt, cnt_n;
  logic       full, full_n;
  logic [7:0] rx, rx_n;
  logic [7:0] tx, tx_n;
  logic [7:0] ptr, ptr_n;
  logic       rw, rw_n;
  logic       addr_ok, addr_ok_n;
  logic       mack_ok, mack_ok_n;
  logic       rd_dly;
  logic       sda_oe_n, busy_n, wr_en_n, rd_en_n;
  logic [7:0] addr_n, wdata_n;
  logic [7:0] byte_in;
  logic       addr_hit;

  // Bring the asynchronous pads into the clk domain; idle bus level is high
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_meta <= 1'b1;
      scl_sync <= 1'b1;
      scl_prev <= 1'b1;
      sda_meta <= 1'b1;
      sda_sync <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_meta <= scl_i;
      scl_sync <= scl_meta;
      scl_prev <= scl_sync;
      sda_meta <= sda_i;
      sda_sync <= sda_meta;
      sda_prev <= sda_sync;
    end
  end

  // START/STOP need SCL steady high, so a coincident SCL edge counts as data
  assign scl_rise  = scl_sync & ~scl_prev;
  assign scl_fall  = ~scl_sync & scl_prev;
  assign start_det = scl_sync & scl_prev & sda_prev & ~sda_sync;
  assign stop_det  = scl_sync & scl_prev & ~sda_prev & sda_sync;

  // Byte as it will look once the current bit is shifted in
  assign byte_in  = {rx[6:0], sda_sync};
  // General call (0) and 10-bit prefixes (11110xx) never match
  assign addr_hit = (byte_in[7:1] == SLAVE_ADDR) &&
                    (byte_in[7:1] != 7'd0) &&
                    (byte_in[7:3] != 5'b11110);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 3'd0;
      full      <= 1'b0;
      rx        <= 8'h00;
      tx        <= 8'h00;
      ptr       <= 8'h00;
      rw        <= 1'b0;
      addr_ok   <= 1'b0;
      mack_ok   <= 1'b0;
      rd_dly    <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      reg_addr  <= 8'h00;
      reg_wdata <= 8'h00;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      full      <= full_n;
      rx        <= rx_n;
      tx        <= tx_n;
      ptr       <= ptr_n;
      rw        <= rw_n;
      addr_ok   <= addr_ok_n;
      mack_ok   <= mack_ok_n;
      rd_dly    <= reg_rd_en;
      sda_oe    <= sda_oe_n;
      busy      <= busy_n;
      reg_wr_en <= wr_en_n;
      reg_rd_en <= rd_en_n;
      reg_addr  <= addr_n;
      reg_wdata <= wdata_n;
    end
  end

  // Next-state and output decode; START/STOP override every state
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    full_n    = full;
    rx_n      = rx;
    tx_n      = rd_dly ? reg_rdata : tx;
    ptr_n     = reg_wr_en ? (ptr + 8'd1) : ptr;
    rw_n      = rw;
    addr_ok_n = addr_ok;
    mack_ok_n = mack_ok;
    sda_oe_n  = sda_oe;
    busy_n    = busy;
    wr_en_n   = 1'b0;
    rd_en_n   = 1'b0;
    addr_n    = reg_addr;
    wdata_n   = reg_wdata;

    if (start_det) begin
      state_n  = S_ADDR;
      cnt_n    = 3'd0;
      full_n   = 1'b0;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else if (stop_det) begin
      state_n  = S_IDLE;
      cnt_n    = 3'd0;
      full_n   = 1'b0;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          sda_oe_n = 1'b0;
        end

        S_ADDR, S_PTR, S_WDATA: begin
          if (scl_rise && !full) begin
            rx_n  = byte_in;
            cnt_n = cnt + 3'd1;
            if (cnt == 3'd7) begin
              full_n = 1'b1;
              if (state == S_ADDR) begin
                addr_ok_n = addr_hit;
                rw_n      = byte_in[0];
                if (addr_hit && byte_in[0]) begin
                  rd_en_n = 1'b1;
                  addr_n  = ptr;
                end
              end
            end
          end else if (scl_fall && full) begin
            full_n = 1'b0;
            cnt_n  = 3'd0;
            case (state)
              S_ADDR: begin
                if (addr_ok) begin
                  sda_oe_n = 1'b1;
                  busy_n   = 1'b1;
                  state_n  = S_ADDR_ACK;
                end else begin
                  state_n  = S_IGNORE;
                end
              end
              S_PTR: begin
                sda_oe_n = 1'b1;
                ptr_n    = rx;
                state_n  = S_PTR_ACK;
              end
              default: begin
                sda_oe_n = 1'b1;
                wr_en_n  = 1'b1;
                addr_n   = ptr;
                wdata_n  = rx;
                state_n  = S_WDATA_ACK;
              end
            endcase
          end
        end

        S_ADDR_ACK: begin
          if (scl_fall) begin
            cnt_n  = 3'd0;
            full_n = 1'b0;
            if (rw) begin
              sda_oe_n = ~tx_n[7];
              tx_n     = {tx_n[6:0], 1'b0};
              state_n  = S_RDATA;
            end else begin
              sda_oe_n = 1'b0;
              state_n  = S_PTR;
            end
          end
        end

        S_PTR_ACK, S_WDATA_ACK: begin
          if (scl_fall) begin
            sda_oe_n = 1'b0;
            cnt_n    = 3'd0;
            full_n   = 1'b0;
            state_n  = S_WDATA;
          end
        end

        S_RDATA: begin
          if (scl_rise && !full) begin
            cnt_n = cnt + 3'd1;
            if (cnt == 3'd7) begin
              full_n = 1'b1;
            end
          end else if (scl_fall) begin
            if (full) begin
              sda_oe_n  = 1'b0;
              full_n    = 1'b0;
              cnt_n     = 3'd0;
              mack_ok_n = 1'b0;
              state_n   = S_MACK;
            end else begin
              sda_oe_n = ~tx_n[7];
              tx_n     = {tx_n[6:0], 1'b0};
            end
          end
        end

        S_MACK: begin
          if (scl_rise && !mack_ok) begin
            ptr_n = ptr + 8'd1;
            if (!sda_sync) begin
              mack_ok_n = 1'b1;
              rd_en_n   = 1'b1;
              addr_n    = ptr + 8'd1;
            end else begin
              busy_n  = 1'b0;
              state_n = S_IGNORE;
            end
          end else if (scl_fall && mack_ok) begin
            mack_ok_n = 1'b0;
            sda_oe_n  = ~tx_n[7];
            tx_n      = {tx_n[6:0], 1'b0};
            cnt_n     = 3'd0;
            full_n    = 1'b0;
            state_n   = S_RDATA;
          end
        end

        S_IGNORE: begin
          sda_oe_n = 1'b0;
        end

        default: begin
          state_n  = S_IDLE;
          sda_oe_n = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench for i2c_slave_regs: a bit-banged I2C master drives the
// open-drain bus, a small register-file model answers the register port,
// and every strobe is logged for comparison against hand-computed values.
module tb_i2c_slave_regs;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_oe;
  logic [7:0] reg_addr;
  logic       reg_wr_en;
  logic [7:0] reg_wdata;
  logic       reg_rd_en;
  logic [7:0] reg_rdata;
  logic       busy;
  logic       scl_bus, sda_bus;

  logic [7:0]  mem [256];
  logic [15:0] wr_log [$];
  logic [7:0]  rd_log [$];
  logic        oe_seen;

  int check_count = 0;
  int pass_count  = 0;

  assign scl_bus = scl_m;
  assign sda_bus = sda_m & ~sda_oe;

  i2c_slave_regs dut (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_bus),
    .sda_i     (sda_bus),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .reg_wr_en (reg_wr_en),
    .reg_wdata (reg_wdata),
    .reg_rd_en (reg_rd_en),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  // 100 MHz system clock
  always #5 clk = ~clk;

  // Register file model: read data valid the cycle after the strobe; logs strobes
  always @(posedge clk) begin
    if (reg_wr_en) begin
      mem[reg_addr] = reg_wdata;
      wr_log.push_back({reg_addr, reg_wdata});
    end
    if (reg_rd_en) begin
      reg_rdata <= mem[reg_addr];
      rd_log.push_back(reg_addr);
    end
    if (sda_oe) oe_seen = 1'b1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  function automatic logic [15:0] wr_at(input int i);
    if (i < wr_log.size()) return wr_log[i];
    return 16'hDEAD;
  endfunction

  function automatic logic [7:0] rd_at(input int i);
    if (i < rd_log.size()) return rd_log[i];
    return 8'hEE;
  endfunction

  // Quarter SCL period of 10 clk; inputs change on the falling clk edge
  task automatic wait_q();
    repeat (10) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    wait_q();
    scl_m = 1'b1; wait_q(); wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    b = sda_bus;  wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] data, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(data[i]);
    read_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(output logic [7:0] data, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      data[i] = b;
    end
    write_bit(~ack);
  endtask

  task automatic clear_logs();
    wr_log.delete();
    rd_log.delete();
    oe_seen = 1'b0;
  endtask

  task automatic applyStimulus();
    logic       ack;
    logic [7:0] data;

    // Reset state
    repeat (5) @(negedge clk);
    checkOutput("rst_sda_oe", sda_oe, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_wr_en", reg_wr_en, 0);
    checkOutput("rst_rd_en", reg_rd_en, 0);
    checkOutput("rst_addr", reg_addr, 8'h00);
    checkOutput("rst_wdata", reg_wdata, 8'h00);
    rst = 1'b0;
    wait_q();

    // Write two bytes starting at 0x10
    clear_logs();
    i2c_start();
    write_byte(8'hAE, ack); checkOutput("wr_ack_addr", ack, 1);
    checkOutput("wr_busy_on", busy, 1);
    write_byte(8'h10, ack); checkOutput("wr_ack_ptr", ack, 1);
    write_byte(8'hA5, ack); checkOutput("wr_ack_d0", ack, 1);
    write_byte(8'h5A, ack); checkOutput("wr_ack_d1", ack, 1);
    i2c_stop();
    checkOutput("wr_count", wr_log.size(), 2);
    checkOutput("wr_strobe0", wr_at(0), 16'h10A5);
    checkOutput("wr_strobe1", wr_at(1), 16'h115A);
    checkOutput("wr_busy_off", busy, 0);
    checkOutput("wr_no_rd", rd_log.size(), 0);

    // Random read: pointer 0x20, repeated start, two bytes
    clear_logs();
    i2c_start();
    write_byte(8'hAE, ack); checkOutput("rr_ack_addr", ack, 1);
    write_byte(8'h20, ack); checkOutput("rr_ack_ptr", ack, 1);
    i2c_start();
    write_byte(8'hAF, ack); checkOutput("rr_ack_raddr", ack, 1);
    read_byte(data, 1'b1); checkOutput("rr_data0", data, 8'h3C);
    read_byte(data, 1'b0); checkOutput("rr_data1", data, 8'hC3);
    checkOutput("rr_busy_nack", busy, 0);
    i2c_stop();
    checkOutput("rr_rd_count", rd_log.size(), 2);
    checkOutput("rr_rd0", rd_at(0), 8'h20);
    checkOutput("rr_rd1", rd_at(1), 8'h21);
    checkOutput("rr_no_wr", wr_log.size(), 0);

    // Address mismatch: never drives SDA, no strobes
    clear_logs();
    i2c_start();
    write_byte(8'hA0, ack); checkOutput("mm_ack_addr", ack, 0);
    write_byte(8'h00, ack); checkOutput("mm_ack_byte", ack, 0);
    i2c_stop();
    checkOutput("mm_oe_seen", oe_seen, 0);
    checkOutput("mm_strobes", wr_log.size() + rd_log.size(), 0);
    checkOutput("mm_busy", busy, 0);

    // Pointer wrap, then current-address read uses the persisted pointer
    clear_logs();
    i2c_start();
    write_byte(8'hAE, ack);
    write_byte(8'hFF, ack);
    write_byte(8'h11, ack);
    write_byte(8'h22, ack); checkOutput("wrap_ack", ack, 1);
    i2c_stop();
    checkOutput("wrap_wr0", wr_at(0), 16'hFF11);
    checkOutput("wrap_wr1", wr_at(1), 16'h0022);
    i2c_start();
    write_byte(8'hAF, ack);
    read_byte(data, 1'b0); checkOutput("cur_data", data, 8'h5B);
    i2c_stop();
    checkOutput("cur_rd_count", rd_log.size(), 1);
    checkOutput("cur_rd0", rd_at(0), 8'h01);

    // STOP in the middle of a data byte discards it
    clear_logs();
    i2c_start();
    write_byte(8'hAE, ack);
    write_byte(8'h30, ack);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
    i2c_stop();
    checkOutput("ab_no_wr", wr_log.size(), 0);
    checkOutput("ab_sda_oe", sda_oe, 0);
    checkOutput("ab_busy", busy, 0);

    // Reset while the target drives a 0 bit (mem[0x30] = 0x6A, bit7 = 0)
    i2c_start();
    write_byte(8'hAF, ack); checkOutput("rs_ack", ack, 1);
    checkOutput("rs_driving", sda_oe, 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rs_released", sda_oe, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_q();

    // A full write after reset still works
    clear_logs();
    i2c_start();
    write_byte(8'hAE, ack); checkOutput("post_ack_addr", ack, 1);
    write_byte(8'h40, ack);
    write_byte(8'h77, ack); checkOutput("post_ack_data", ack, 1);
    i2c_stop();
    checkOutput("post_wr_count", wr_log.size(), 1);
    checkOutput("post_wr0", wr_at(0), 16'h4077);
    checkOutput("post_busy", busy, 0);
  endtask

  // Preload the register model, run the sequence, report
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[8'h20] = 8'h3C;
    mem[8'h21] = 8'hC3;
    reg_rdata = 8'h00;
    oe_seen = 1'b0;
    applyStimulus();
    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
